insn_loader: RTL

- Writer side of the instruction-memory fetch interface.
- Receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory from word address 0.
- Holds the core in reset until a complete program has landed.
- Replaces hierarchical backdoor preloading of instruction memory with a synthesizable load path.

---
 rtl/insn_loader_pkg.sv | 21 ++
 rtl/insn_loader_byte_packer.sv | 44 ++++
 rtl/insn_loader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/insn_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, byte-lane
// indices and default geometry.
package insn_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DEPTH  = 1024;

endpackage

// File: rtl/insn_loader_byte_packer.sv
// Packs an 8-bit valid/ready stream into little-endian 32-bit words. The word
// and its valid pulse are presented in the same cycle the fourth byte lands.
module insn_loader_byte_packer
    import insn_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_ready,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] lanes_r;
    logic [1:0]  idx_r;
    logic        accept_s;

    assign accept_s   = in_valid && in_ready;
    assign word       = {in_data, lanes_r};
    assign word_valid = accept_s && (idx_r == LANE3);

    // Lane fill: the top lane is never stored, it is forwarded straight into word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes_r <= 24'd0;
            idx_r   <= LANE0;
        end else if (accept_s) begin
            case (idx_r)
                LANE0:   lanes_r[7:0]   <= in_data;
                LANE1:   lanes_r[15:8]  <= in_data;
                LANE2:   lanes_r[23:16] <= in_data;
                LANE3:   lanes_r        <= 24'd0;
                default: lanes_r        <= 24'd0;
            endcase
            idx_r <= idx_r + 2'd1;
        end else begin
            lanes_r <= lanes_r;
            idx_r   <= idx_r;
        end
    end

endmodule

// File: rtl/insn_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, writes words
// from address 0 and holds the core in reset until the program is complete.
module insn_loader
    import insn_loader_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t          state_r;
    logic [ADDR_W:0] len_r;
    logic [31:0]     word_s;
    logic            word_valid_s;
    logic            pack_clear_s;

    // Any partial word is discarded whenever the loader stops accepting bytes.
    assign pack_clear_s = ~in_ready;

    insn_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clear_s),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Load sequencer: owns every registered output of the loader.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            len_r        <= {(ADDR_W+1){1'b0}};
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {ADDR_W{1'b0}};
            mem_wdata    <= 32'd0;
            core_hold    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= {(ADDR_W+1){1'b0}};
        end else begin
            mem_we <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r      <= ST_LEN;
                        in_ready     <= 1'b1;
                        busy         <= 1'b1;
                        core_hold    <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= {(ADDR_W+1){1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_LEN: begin
                    if (word_valid_s) begin
                        if (word_s == 32'd0) begin
                            state_r   <= ST_DONE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                        end else if (word_s > DEPTH_W) begin
                            state_r  <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state_r <= ST_DATA;
                            len_r   <= word_s[ADDR_W:0];
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DATA: begin
                    // words_loaded already counts the word being written this cycle.
                    if (mem_we && (words_loaded == len_r)) begin
                        state_r   <= ST_DONE;
                        in_ready  <= 1'b0;
                        busy      <= 1'b0;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end else if (word_valid_s) begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= word_s;
                        mem_addr     <= words_loaded[ADDR_W-1:0];
                        words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                    core_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
